encoder4to2_seq: RTL and testbench

Registered 4-to-2 priority encoder with request capture and a valid/ready output handshake. It is the return path for the 2-to-4 decoder. It accepts one-hot or multi-hot request lines shaped like the decoder's p/q/r/s outputs, latches them as pending, and emits one 2-bit code per accepted request, highest priority first. Each code is held stable until the downstream consumer takes it.

---
 rtl/encoder4to2_seq_pkg.sv | 36 +++
 rtl/prio_sel4.sv | 15 +
 rtl/encoder4to2_seq.sv | 93 +++++++++
 tb/tb_encoder4to2_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/encoder4to2_seq_pkg.sv
// Shared sizes, FSM state type and selection helpers for the 4-to-2 sequential encoder.
// Kept free of module-specific logic so the bench can import the same state type.
package encoder_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // The last index written in the scan wins, so scan direction sets the priority.
    function automatic logic [CODE_W-1:0] sel(input logic [N_REQ-1:0] r, input logic high);
        logic [CODE_W-1:0] idx;
        idx = '0;
        if (high) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (r[i]) idx = CODE_W'(i);
            end
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (r[i]) idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_sel4.sv
// Combinational 4-input priority selector: index of the winning set bit plus an any-set flag.
module prio_sel4
    import encoder_pkg::*;
#(
    parameter int unsigned PRIORITY_HIGH = 1
) (
    input  logic [N_REQ-1:0]  req_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              any_o
);

    assign idx_o = sel(req_i, PRIORITY_HIGH != 0);
    assign any_o = |req_i;

endmodule

// File: rtl/encoder4to2_seq.sv
// Registered 4-to-2 priority encoder: captures request lines as pending and presents one
// code per request over a valid/ready handshake, highest-priority first.
module encoder4to2_seq
    import encoder_pkg::*;
#(
    parameter int unsigned PRIORITY_HIGH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    input  logic              ready,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [N_REQ-1:0]  pending,
    output logic              overflow,
    output state_t            state_dbg
);

    // Handshake: a code transfers on any cycle where valid && ready are both high at the
    // rising edge; once valid rises, code stays frozen and valid stays high until that transfer.

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic                overflow_q, overflow_d;

    logic [N_REQ-1:0]    served;
    logic [N_REQ-1:0]    avail;
    logic [N_REQ-1:0]    req_m;
    logic [CODE_W-1:0]   pend_idx, avail_idx;
    logic                pend_any, avail_any;

    // The presented code stays in pending until it is accepted.
    assign served     = (valid && ready) ? onehot(code_q) : '0;
    assign avail      = pending_q & ~served;
    assign req_m      = en ? req : '0;
    assign pending_d  = avail | req_m;
    assign overflow_d = |(req_m & avail);

    prio_sel4 #(.PRIORITY_HIGH(PRIORITY_HIGH)) u_sel_pending (
        .req_i (pending_q),
        .idx_o (pend_idx),
        .any_o (pend_any)
    );

    prio_sel4 #(.PRIORITY_HIGH(PRIORITY_HIGH)) u_sel_avail (
        .req_i (avail),
        .idx_o (avail_idx),
        .any_o (avail_any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (pend_any) begin
                    code_d  = pend_idx;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (avail_any) code_d = avail_idx;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid     = (state_q == HOLD);
    assign code      = code_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_encoder4to2_seq.sv
// Bench for encoder4to2_seq: two instances (high- and low-index priority) driven in lockstep,
// checked every cycle against a set-based reference model through per-instance expected queues.
module tb_encoder4to2_seq;
    import encoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, ready;
    logic [3:0] req;

    logic [1:0] code_hi, code_lo;
    logic       valid_hi, valid_lo, overflow_hi, overflow_lo;
    logic [3:0] pending_hi, pending_lo;
    state_t     state_hi, state_lo;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    // Expected word per cycle: {valid, code[1:0], pending[3:0], overflow}
    logic [7:0] exp_hi[$];
    logic [7:0] exp_lo[$];

    // Clock / reset
    always #5 clk = ~clk;

    encoder4to2_seq #(.PRIORITY_HIGH(1)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
        .code(code_hi), .valid(valid_hi), .pending(pending_hi),
        .overflow(overflow_hi), .state_dbg(state_hi)
    );

    encoder4to2_seq #(.PRIORITY_HIGH(0)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
        .code(code_lo), .valid(valid_lo), .pending(pending_lo),
        .overflow(overflow_lo), .state_dbg(state_lo)
    );

    // Reference model: a set of outstanding request indices plus "the code on offer, if any".
    bit m_pend[2][4];
    bit m_offer[2];
    int m_code[2];
    bit m_ovf[2];

    function automatic int pick(input bit s[4], input bit high);
        int best = -1;
        for (int i = 0; i < 4; i++) begin
            if (s[i] && (high || best < 0)) best = i;
        end
        return best;
    endfunction

    task automatic model_step(input int k);
        bit avail[4];
        bit fresh[4];
        bit any_avail = 0;
        bit any_pend = 0;
        bit taken = m_offer[k] && ready;
        logic [3:0] pv;
        m_ovf[k] = 0;
        for (int i = 0; i < 4; i++) begin
            avail[i] = m_pend[k][i] && !(taken && m_code[k] == i);
            fresh[i] = en && req[i];
            if (fresh[i] && avail[i]) m_ovf[k] = 1;
            any_avail |= avail[i];
            any_pend  |= m_pend[k][i];
        end
        if (!m_offer[k]) begin
            if (any_pend) begin
                m_offer[k] = 1;
                m_code[k]  = pick(m_pend[k], k == 0);
            end
        end else if (taken) begin
            if (any_avail) m_code[k] = pick(avail, k == 0);
            else           m_offer[k] = 0;
        end
        for (int i = 0; i < 4; i++) m_pend[k][i] = avail[i] || fresh[i];
        if (rst) begin
            for (int i = 0; i < 4; i++) m_pend[k][i] = 0;
            m_offer[k] = 0;
            m_code[k]  = 0;
            m_ovf[k]   = 0;
        end
        for (int i = 0; i < 4; i++) pv[i] = m_pend[k][i];
        if (k == 0) exp_hi.push_back({m_offer[k], 2'(m_code[k]), pv, m_ovf[k]});
        else        exp_lo.push_back({m_offer[k], 2'(m_code[k]), pv, m_ovf[k]});
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        logic [7:0] e, a;
        cyc_n++;
        if (exp_hi.size() > 0) begin
            e = exp_hi.pop_front();
            a = {valid_hi, code_hi, pending_hi, overflow_hi};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL hi_outputs cycle %0d: got v=%b c=%b p=%b o=%b, want v=%b c=%b p=%b o=%b",
                         cyc_n, a[7], a[6:5], a[4:1], a[0], e[7], e[6:5], e[4:1], e[0]);
            end
        end
        if (exp_lo.size() > 0) begin
            e = exp_lo.pop_front();
            a = {valid_lo, code_lo, pending_lo, overflow_lo};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL lo_outputs cycle %0d: got v=%b c=%b p=%b o=%b, want v=%b c=%b p=%b o=%b",
                         cyc_n, a[7], a[6:5], a[4:1], a[0], e[7], e[6:5], e[4:1], e[0]);
            end
        end
    end

    // Driver: inputs change at the falling edge, sampled at the next rising edge
    task automatic cyc(input logic r, input logic e, input logic [3:0] q, input logic rd);
        rst   = r;
        en    = e;
        req   = q;
        ready = rd;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'b0000, rd);
    endtask

    initial begin
        // Reset held with requests present, then requests right after release
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'b1111, 1'b1);
        cyc(1'b0, 1'b1, 4'b1111, 1'b1);
        idle(6, 1'b1);
        // Single request
        cyc(1'b0, 1'b1, 4'b0100, 1'b1);
        idle(4, 1'b1);
        // Multi-hot, serialised in priority order
        cyc(1'b0, 1'b1, 4'b1011, 1'b1);
        idle(5, 1'b1);
        // Backpressure
        cyc(1'b0, 1'b1, 4'b0001, 1'b0);
        idle(6, 1'b0);
        idle(3, 1'b1);
        // Overflow merge, then re-request during the serve cycle
        cyc(1'b0, 1'b1, 4'b0010, 1'b0);
        idle(2, 1'b0);
        cyc(1'b0, 1'b1, 4'b0010, 1'b0);
        idle(1, 1'b0);
        cyc(1'b0, 1'b1, 4'b0010, 1'b1);
        idle(4, 1'b1);
        // Enable masking
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b1111, 1'b1);
        // Reset while holding
        cyc(1'b0, 1'b1, 4'b0110, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0);
        idle(2, 1'b1);
        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
        end
        idle(8, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
